// File: rtl/product_register.sv
// Shift/accumulate product register with a built-in step counter for multdiv.
// Define PRODUCT_REGISTER_CLEAR_EN to add a synchronous `clear` input.
module product_register #(
    parameter int WIDTH = 65,
    parameter int UPPER = 32,
    parameter int SHIFT = 2,
    parameter int COUNT = 16,
    localparam int SW   = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_enable,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [UPPER-1:0] upper_in,
`ifdef PRODUCT_REGISTER_CLEAR_EN
    input  logic             clear,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic [SW-1:0]    step
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [SW-1:0] COUNT_W = SW'(COUNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SW-1:0]    step_q, step_d;
    logic [SW-1:0]    step_inc;
    logic [WIDTH-1:0] src;
    logic             clear_req;

`ifdef PRODUCT_REGISTER_CLEAR_EN
    assign clear_req = clear;
`else
    assign clear_req = 1'b0;
`endif

    assign step_inc = step_q + SW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            step_q  <= step_d;
        end
    end

    // op[0] selects write-upper-then-shift; sign comes from the new upper field
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        step_d  = step_q;
        src     = data_q;
        if (input_enable) begin
            if (clear_req) begin
                state_d = S_IDLE;
                data_d  = '0;
                step_d  = '0;
            end else begin
                case (op)
                    2'b01: begin
                        state_d = S_BUSY;
                        data_d  = data_in;
                        step_d  = '0;
                    end
                    2'b10, 2'b11: begin
                        if (state_q == S_BUSY) begin
                            if (op[0])
                                src = {upper_in, data_q[WIDTH-UPPER-1:0]};
                            data_d = $signed(src) >>> SHIFT;
                            step_d = step_inc;
                            if (step_inc == COUNT_W)
                                state_d = S_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_out = data_q;
    assign step     = step_q;
    assign busy     = (state_q == S_BUSY);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_product_register.sv
// Randomized and directed bench for product_register against a behavioural model.
module tb_product_register;

    localparam int W  = 65;
    localparam int U  = 32;
    localparam int N  = 16;
    localparam int SW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          input_enable;
    logic [1:0]    op;
    logic [W-1:0]  data_in;
    logic [U-1:0]  upper_in;
    logic          clr_v;
    logic [W-1:0]  data_out;
    logic          busy;
    logic          done;
    logic [SW-1:0] step;

    int vectors = 0;
    int miscompares = 0;

    logic signed [W-1:0] m_data;
    int                  m_step;
    bit                  m_loaded;

    product_register dut (
        .clk(clk),
        .reset(reset),
        .input_enable(input_enable),
        .op(op),
        .data_in(data_in),
        .upper_in(upper_in),
`ifdef PRODUCT_REGISTER_CLEAR_EN
        .clear(clr_v),
`endif
        .data_out(data_out),
        .busy(busy),
        .done(done),
        .step(step)
    );

    always #5 clk = ~clk;

    function automatic bit m_busy();
        return m_loaded && (m_step < N);
    endfunction

    function automatic bit m_done();
        return m_loaded && (m_step == N);
    endfunction

    task automatic m_reset();
        m_data   = '0;
        m_step   = 0;
        m_loaded = 1'b0;
    endtask

    task automatic model(input logic en, input logic [1:0] o,
                         input logic [W-1:0] d, input logic [U-1:0] u,
                         input logic c);
        logic signed [W-1:0] v;
        if (!en) return;
`ifdef PRODUCT_REGISTER_CLEAR_EN
        if (c) begin
            m_reset();
            return;
        end
`endif
        if (o == 2'b01) begin
            m_data   = d;
            m_step   = 0;
            m_loaded = 1'b1;
        end else if (o[1] && m_busy()) begin
            v = m_data;
            if (o[0]) v[W-1:W-U] = u;
            m_data = v >>> 2;
            m_step = m_step + 1;
        end
    endtask

    task automatic expect_val(input string tag, input logic [W-1:0] got,
                              input logic [W-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        expect_val({tag, ".data"}, data_out, m_data);
        expect_val({tag, ".step"}, W'(step), W'(m_step));
        expect_val({tag, ".busy"}, W'(busy), W'(m_busy()));
        expect_val({tag, ".done"}, W'(done), W'(m_done()));
    endtask

    task automatic tick(input logic en, input logic [1:0] o,
                        input logic [W-1:0] d, input logic [U-1:0] u,
                        input logic c, input string tag);
        input_enable = en;
        op           = o;
        data_in      = d;
        upper_in     = u;
        clr_v        = c;
        @(posedge clk);
        model(en, o, d, u, c);
        #1 check_all(tag);
    endtask

    initial begin
        logic [W-1:0] rd;
        logic [1:0]   ro;
        logic         re;
        logic         rc;
        reset        = 1'b1;
        input_enable = 1'b0;
        op           = 2'b00;
        data_in      = '0;
        upper_in     = '0;
        clr_v        = 1'b0;
        m_reset();
        #1 check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        tick(1, 2'b10, '0, '0, 0, "idle_shift");
        tick(1, 2'b01, 65'h10, '0, 0, "load");
        tick(1, 2'b10, '0, '0, 0, "shift1");
        expect_val("shift1_val", data_out, 65'h4);
        expect_val("shift1_step", W'(step), W'(1));
        expect_val("shift1_busy", W'(busy), W'(1));

        tick(1, 2'b01, 65'h10, '0, 0, "reload");
        #2 reset = 1'b1;
        m_reset();
        #1 check_all("async_reset");
        expect_val("async_reset_data", data_out, '0);
        @(negedge clk);
        reset = 1'b0;
        tick(1, 2'b10, '0, '0, 0, "post_reset_shift");
        expect_val("post_reset_data", data_out, '0);

        tick(1, 2'b01, 65'h1_0000_0000_0000_0000, '0, 0, "load_neg");
        tick(1, 2'b10, '0, '0, 0, "sign_shift");
        expect_val("sign_shift_val", data_out, 65'h1_C000_0000_0000_0000);
        tick(1, 2'b01, '0, '0, 0, "load_zero");
        tick(1, 2'b11, '0, 32'hFFFF_FFFC, 0, "wr_shift");
        expect_val("wr_shift_val", data_out, 65'h1_FFFF_FFFE_0000_0000);

        tick(1, 2'b01, 65'h1_2345_6789_ABCD_EF01, '0, 0, "load_c");
        for (int i = 1; i <= N; i++) tick(1, 2'b10, '0, '0, 0, "complete");
        expect_val("complete_done", W'(done), W'(1));
        expect_val("complete_busy", W'(busy), W'(0));
        expect_val("complete_step", W'(step), W'(N));
        rd = data_out;
        tick(1, 2'b10, '0, '0, 0, "after_done");
        expect_val("after_done_data", data_out, rd);
        tick(1, 2'b01, 65'h55, '0, 0, "reload_done");
        expect_val("reload_done", W'(done), W'(0));

        for (int i = 0; i < 5; i++) tick(1, 2'b10, '0, '0, 0, "pre_stall");
        for (int i = 0; i < 3; i++) tick(0, 2'b10, '0, '0, 0, "stall");
        expect_val("stall_step", W'(step), W'(5));
        for (int i = 0; i < 10; i++) tick(1, 2'b10, '0, '0, 0, "post_stall");
        expect_val("stall_busy15", W'(busy), W'(1));
        tick(1, 2'b10, '0, '0, 0, "stall_last");
        expect_val("stall_done16", W'(done), W'(1));

`ifdef PRODUCT_REGISTER_CLEAR_EN
        tick(1, 2'b01, 65'h77, '0, 0, "clr_load");
        tick(1, 2'b10, '0, '0, 0, "clr_shift");
        tick(0, 2'b01, 65'h9, '0, 1, "clr_disabled");
        expect_val("clr_disabled_busy", W'(busy), W'(1));
        tick(1, 2'b01, 65'h9, '0, 1, "clr_active");
        expect_val("clr_data", data_out, '0);
        expect_val("clr_busy", W'(busy), W'(0));
`endif

        for (int i = 0; i < 600; i++) begin
            rd = {$urandom, $urandom, $urandom};
            ro = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) < 7 && ro == 2'b01) ro = 2'b10;
            re = ($urandom_range(0, 9) < 8);
`ifdef PRODUCT_REGISTER_CLEAR_EN
            rc = ($urandom_range(0, 49) == 0);
`else
            rc = 1'b0;
`endif
            tick(re, ro, rd, 32'($urandom), rc, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
